// File: rtl/weight_fetch_ctrl.sv
// Read-side controller between the conv weight BRAM wrapper and the MAC array:
// fetches KERNEL_SIZE weights per kernel, one outstanding read at a time, and streams packed kernels.
module weight_fetch_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int KERNEL_SIZE = 9,
  parameter int CNT_WIDTH   = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                              iclk,
  input  logic                              irst,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [CNT_WIDTH-1:0]              num_kernels,
  output logic                              busy,
  output logic                              done,
  output logic                              err_timeout,
  output logic                              mem_ena,
  output logic                              mem_wea,
  output logic [ADDR_WIDTH-1:0]             mem_addra,
  output logic                              mem_enb,
  output logic [ADDR_WIDTH-1:0]             mem_addrb,
  input  logic                              mem_valid,
  input  logic [DATA_WIDTH-1:0]             mem_doutb,
  output logic                              kw_valid,
  input  logic                              kw_ready,
  output logic [DATA_WIDTH*KERNEL_SIZE-1:0] kw_data,
  output logic                              kw_last
);

  localparam int IDX_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int KW_W  = DATA_WIDTH * KERNEL_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [KW_W-1:0]       kw_data_q, kw_data_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  mem_ena_q, mem_ena_d;
  logic                  mem_enb_q, mem_enb_d;
  logic                  kw_valid_q, kw_valid_d;
  logic                  kw_last_q, kw_last_d;

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    wdog_d     = wdog_q;
    kw_data_d  = kw_data_q;
    err_d      = err_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_kernels != {CNT_WIDTH{1'b0}}) begin
            cur_addr_d = base_addr;
            num_d      = num_kernels;
            cnt_d      = {CNT_WIDTH{1'b0}};
            idx_d      = {IDX_W{1'b0}};
            wdog_d     = {WD_W{1'b0}};
            state_d    = ST_REQ;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        wdog_d  = {WD_W{1'b0}};
        state_d = ST_WAIT_RD;
      end

      ST_WAIT_RD: begin
        if (mem_valid) begin
          kw_data_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = mem_doutb;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          wdog_d     = {WD_W{1'b0}};
          if (idx_q == IDX_W'(KERNEL_SIZE - 1)) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = ST_OUT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_REQ;
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // Lost response: abort without done, leaving the sticky flag for software
          err_d   = 1'b1;
          wdog_d  = {WD_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      ST_OUT: begin
        if (kw_ready) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if ((cnt_q + CNT_WIDTH'(1)) == num_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    mem_ena_d  = (state_d == ST_REQ);
    mem_enb_d  = (state_d == ST_REQ) || (state_d == ST_WAIT_RD);
    kw_valid_d = (state_d == ST_OUT);
    kw_last_d  = (state_d == ST_OUT) && ((cnt_d + CNT_WIDTH'(1)) == num_d);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= {ADDR_WIDTH{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      cnt_q      <= {CNT_WIDTH{1'b0}};
      num_q      <= {CNT_WIDTH{1'b0}};
      wdog_q     <= {WD_W{1'b0}};
      kw_data_q  <= {KW_W{1'b0}};
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_ena_q  <= 1'b0;
      mem_enb_q  <= 1'b0;
      kw_valid_q <= 1'b0;
      kw_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      wdog_q     <= wdog_d;
      kw_data_q  <= kw_data_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mem_ena_q  <= mem_ena_d;
      mem_enb_q  <= mem_enb_d;
      kw_valid_q <= kw_valid_d;
      kw_last_q  <= kw_last_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign mem_ena     = mem_ena_q;
  assign mem_wea     = 1'b0;
  assign mem_addra   = cur_addr_q;
  assign mem_enb     = mem_enb_q;
  assign mem_addrb   = cur_addr_q;
  assign kw_valid    = kw_valid_q;
  assign kw_data     = kw_data_q;
  assign kw_last     = kw_last_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a READ_LATENCY=2 wrapper model that
// returns addr+0x100 three cycles after each REQ and can drop a chosen read.
module tb_weight_fetch_ctrl;
  localparam int KW = 144;

  logic          iclk;
  logic          irst;
  logic          start;
  logic [15:0]   base_addr;
  logic [7:0]    num_kernels;
  logic          busy, done, err_timeout;
  logic          mem_ena, mem_wea, mem_enb;
  logic [15:0]   mem_addra, mem_addrb;
  logic          mem_valid;
  logic [15:0]   mem_doutb;
  logic          kw_valid, kw_ready, kw_last;
  logic [KW-1:0] kw_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // wrapper model state and monitors
  logic          v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [15:0]   d1 = 16'h0, d2 = 16'h0, d3 = 16'h0;
  int            rd_num = 0, drop_at = 0;
  int            done_cnt = 0, kw_cnt = 0, busy_cnt = 0, vld_cnt = 0;
  logic [15:0]   ena_q[$];

  weight_fetch_ctrl dut (
    .iclk(iclk), .irst(irst), .start(start), .base_addr(base_addr),
    .num_kernels(num_kernels), .busy(busy), .done(done), .err_timeout(err_timeout),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_enb(mem_enb),
    .mem_addrb(mem_addrb), .mem_valid(mem_valid), .mem_doutb(mem_doutb),
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data), .kw_last(kw_last)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    mem_valid = v3;
    mem_doutb = d3;
    v3 = v2; d3 = d2;
    v2 = v1; d2 = d1;
    v1 = 1'b0;
    if (mem_ena) begin
      rd_num = rd_num + 1;
      ena_q.push_back(mem_addra);
      if (rd_num != drop_at) begin
        v1 = 1'b1;
        d1 = mem_addra + 16'h0100;
      end
    end
    if (done)      done_cnt = done_cnt + 1;
    if (kw_valid)  kw_cnt   = kw_cnt + 1;
    if (busy)      busy_cnt = busy_cnt + 1;
    if (mem_valid) vld_cnt  = vld_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iclk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic start_job(input logic [15:0] b, input logic [7:0] n, output int s);
    base_addr   = b;
    num_kernels = n;
    start       = 1'b1;
    s           = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_kw(input int limit);
    int n;
    n = 0;
    while (!kw_valid && n < limit) begin
      tick();
      n = n + 1;
    end
    if (!kw_valid) check_value("wait_kw_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [KW-1:0] kernel_exp(input logic [15:0] a0);
    logic [KW-1:0] r;
    logic [15:0]   w;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      w = a0 + 16'(i) + 16'h0100;
      r[i*16 +: 16] = w;
    end
    return r;
  endfunction

  function automatic int addr_seq_bad(input logic [15:0] a0, input int n);
    int bad;
    logic [15:0] a;
    bad = 0;
    if (ena_q.size() != n) bad = bad + 1000;
    for (int i = 0; i < n && i < ena_q.size(); i++) begin
      a = a0 + 16'(i);
      if (ena_q[i] !== a) bad = bad + 1;
    end
    return bad;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int s;
    logic [KW-1:0] cap;
    irst = 1'b1; start = 1'b0; base_addr = 16'h0; num_kernels = 8'd0; kw_ready = 1'b0;
    repeat (3) tick();
    check_value("rst_flags", {busy, done, err_timeout, mem_ena, mem_wea, mem_enb, kw_valid, kw_last}, 8'h00);
    check_value("rst_addr", mem_addra, 16'h0000);
    check_value("rst_data", kw_data, '0);
    irst = 1'b0;
    tick();

    // 1: single kernel, ready held high
    kw_ready = 1'b1;
    ena_q.delete();
    start_job(16'h0010, 8'd1, s);
    check_value("t1_req", {mem_ena, mem_enb, busy, mem_wea}, 4'b1110);
    check_value("t1_req_addr", {mem_addra, mem_addrb}, 32'h0010_0010);
    wait_kw(60);
    check_value("t1_latency", cyc - s, 37);
    check_value("t1_data", kw_data, kernel_exp(16'h0010));
    check_value("t1_last", kw_last, 1'b1);
    tick();
    check_value("t1_done", {done, busy, kw_valid}, 3'b100);
    tick();
    check_value("t1_done_pulse", done, 1'b0);

    // 2: three kernels, 5-cycle stall on each
    kw_ready = 1'b0;
    ena_q.delete();
    done_cnt = 0;
    start_job(16'h0010, 8'd3, s);
    for (int k = 0; k < 3; k++) begin
      wait_kw(60);
      cap = kw_data;
      check_value("t2_data", kw_data, kernel_exp(16'h0010 + 16'(9 * k)));
      check_value("t2_last", kw_last, (k == 2) ? 1'b1 : 1'b0);
      for (int j = 0; j < 5; j++) begin
        tick();
        check_value("t2_stall_data", kw_data, cap);
        check_value("t2_stall_valid", kw_valid, 1'b1);
      end
      kw_ready = 1'b1;
      tick();
      kw_ready = 1'b0;
    end
    repeat (3) tick();
    check_value("t2_done_count", done_cnt, 1);
    check_value("t2_addr_seq", addr_seq_bad(16'h0010, 27), 0);

    // 3: zero kernels
    ena_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    start_job(16'h0050, 8'd0, s);
    check_value("t3_done", {done, busy}, 2'b10);
    repeat (4) tick();
    check_value("t3_no_reads", ena_q.size(), 0);
    check_value("t3_no_busy", busy_cnt, 0);
    check_value("t3_done_count", done_cnt, 1);

    // 4: fourth read lost -> watchdog abort
    kw_ready = 1'b1;
    drop_at  = 4;
    rd_num   = 0;
    done_cnt = 0;
    start_job(16'h0060, 8'd1, s);
    repeat (27) tick();
    check_value("t4_before_abort", {err_timeout, busy, mem_enb}, 3'b011);
    tick();
    check_value("t4_abort", {err_timeout, busy, mem_enb, kw_valid}, 4'b1000);
    repeat (3) tick();
    check_value("t4_no_done", done_cnt, 0);
    drop_at = 0;
    start_job(16'h0070, 8'd1, s);
    check_value("t4_err_cleared", {err_timeout, busy}, 2'b01);
    wait_kw(60);
    check_value("t4_retry_data", kw_data, kernel_exp(16'h0070));
    tick();
    check_value("t4_retry_done", done, 1'b1);

    // 5: address wrap across 0xFFFF
    ena_q.delete();
    start_job(16'hFFFC, 8'd1, s);
    wait_kw(60);
    check_value("t5_data", kw_data, kernel_exp(16'hFFFC));
    tick();
    check_value("t5_done", done, 1'b1);
    check_value("t5_end_addr", mem_addra, 16'h0005);
    check_value("t5_addr_seq", addr_seq_bad(16'hFFFC, 9), 0);

    // 6: reset during fifth WAIT_RD, late response ignored
    kw_ready = 1'b1;
    kw_cnt   = 0;
    ena_q.delete();
    start_job(16'h0200, 8'd1, s);
    repeat (17) tick();
    check_value("t6_in_wait", {mem_ena, mem_enb, 3'(ena_q.size())}, 5'b01101);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    vld_cnt = 0;
    check_value("t6_rst_flags", {busy, done, err_timeout, mem_ena, mem_enb, kw_valid, kw_last}, 7'h00);
    check_value("t6_rst_addr", mem_addra, 16'h0000);
    check_value("t6_rst_data", kw_data, '0);
    repeat (5) tick();
    check_value("t6_late_valid_seen", vld_cnt, 1);
    check_value("t6_idle_after", {busy, mem_ena, mem_enb}, 3'b000);
    check_value("t6_addr_after", mem_addra, 16'h0000);
    check_value("t6_no_kw_valid", kw_cnt, 0);
    start_job(16'h0300, 8'd1, s);
    wait_kw(60);
    check_value("t6_fresh_latency", cyc - s, 37);
    check_value("t6_fresh_data", kw_data, kernel_exp(16'h0300));
    tick();
    check_value("t6_fresh_done", done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
